// File: rtl/DecoderPkg.sv
// Opcode enumeration and per-format field layouts shared by the decoder
// and its inverse, the encoder.
//   Op        : 7-bit major opcode values
//   *_fmt_t   : packed 32-bit layouts for the R/I/S/B/U/J formats
package DecoderPkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_ALUI   = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_ALU    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } Op;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_fmt_t;

  typedef struct packed {
    logic [11:0] imm11_0;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_fmt_t;

  typedef struct packed {
    logic [6:0] imm11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm4_0;
    logic [6:0] opcode;
  } s_fmt_t;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm4_1;
    logic       imm11;
    logic [6:0] opcode;
  } b_fmt_t;

  typedef struct packed {
    logic [19:0] imm31_12;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_fmt_t;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm10_1;
    logic       imm11;
    logic [7:0] imm19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } j_fmt_t;

endpackage

// File: rtl/hippo_encoder_pkg.sv
// Immediate range limits, funct7 constants and small helpers used by the
// encoder's range check.
package hippo_encoder_pkg;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // Signed inclusive range test on a full 32-bit immediate.
  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

  // funct3 values that make OP_ALUI a shift (shamt in imm[4:0]).
  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/hippo_encoder_fifo.sv
// Output word FIFO for the encoder.
//   i_clk, i_reset (async, active-low)
//   i_push/i_data : enqueue one word (ignored when full)
//   i_pop         : drop the head word (ignored when empty)
//   o_data        : head word, forced to 0 when empty
//   o_count       : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module hippo_encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = i_push && (count != FULL_COUNT);
  assign pop_ok  = i_pop && (count != '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_data;
  end

  assign o_data  = (count != '0) ? mem[rd_ptr] : '0;
  assign o_count = count;

endmodule

// File: rtl/hippo_encoder.sv
// Instruction encoder: the inverse of the decoder. Takes decoded fields,
// range-checks the immediate for the opcode's format, builds the 32-bit
// word combinationally and queues legal words in an output FIFO.
//   i_clk, i_reset (async, active-low)
//   i_valid/o_ready         : request handshake
//   i_op, i_rd, i_rs1, i_rs2, i_funct3, i_sub, i_imm : decoded fields
//   o_valid/i_ready/o_instr : head-of-FIFO handshake and word
//   o_err                   : one-cycle pulse after an accepted illegal request
//   o_err_sticky/i_err_clr  : latched error flag and its clear
//   o_count                 : FIFO occupancy
module hippo_encoder
  import DecoderPkg::*;
  import hippo_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [6:0]             i_op,
  input  logic [4:0]             i_rd,
  input  logic [4:0]             i_rs1,
  input  logic [4:0]             i_rs2,
  input  logic [2:0]             i_funct3,
  input  logic                   i_sub,
  input  logic [31:0]            i_imm,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [31:0]            o_instr,
  output logic                   o_err,
  output logic                   o_err_sticky,
  input  logic                   i_err_clr,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  r_fmt_t      f_r;
  i_fmt_t      f_i;
  s_fmt_t      f_s;
  b_fmt_t      f_b;
  u_fmt_t      f_u;
  j_fmt_t      f_j;
  logic        shift_op;
  logic [6:0]  funct7_sel;
  logic [31:0] enc_word;
  logic        enc_legal;

  logic        live;
  logic        err_q;
  logic        sticky_q;
  logic        accept;
  logic        push;
  logic        reject;
  logic        pop;
  logic [CW-1:0] count;

  assign shift_op   = (i_op == OP_ALUI) && is_shift_f3(i_funct3);
  assign funct7_sel = i_sub ? FUNCT7_ALT : FUNCT7_BASE;

  // Every format is built in parallel; the opcode only selects one.
  assign f_r = '{funct7: funct7_sel, rs2: i_rs2, rs1: i_rs1, funct3: i_funct3,
                 rd: i_rd, opcode: i_op};
  assign f_i = '{imm11_0: shift_op ? {funct7_sel, i_imm[4:0]} : i_imm[11:0],
                 rs1: i_rs1, funct3: i_funct3, rd: i_rd, opcode: i_op};
  assign f_s = '{imm11_5: i_imm[11:5], rs2: i_rs2, rs1: i_rs1, funct3: i_funct3,
                 imm4_0: i_imm[4:0], opcode: i_op};
  assign f_b = '{imm12: i_imm[12], imm10_5: i_imm[10:5], rs2: i_rs2, rs1: i_rs1,
                 funct3: i_funct3, imm4_1: i_imm[4:1], imm11: i_imm[11], opcode: i_op};
  assign f_u = '{imm31_12: i_imm[31:12], rd: i_rd, opcode: i_op};
  assign f_j = '{imm20: i_imm[20], imm10_1: i_imm[10:1], imm11: i_imm[11],
                 imm19_12: i_imm[19:12], rd: i_rd, opcode: i_op};

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (i_op)
      OP_LUI, OP_AUIPC: begin
        enc_word  = f_u;
        enc_legal = (i_imm[11:0] == 12'd0);
      end
      OP_JAL: begin
        enc_word  = f_j;
        enc_legal = imm_in_range(i_imm, IMM_J_MIN, IMM_J_MAX) && !i_imm[0];
      end
      OP_BRANCH: begin
        enc_word  = f_b;
        enc_legal = imm_in_range(i_imm, IMM_B_MIN, IMM_B_MAX) && !i_imm[0];
      end
      OP_STORE: begin
        enc_word  = f_s;
        enc_legal = imm_in_range(i_imm, IMM_I_MIN, IMM_I_MAX);
      end
      OP_ALU: begin
        enc_word  = f_r;
        enc_legal = 1'b1;
      end
      OP_ALUI: begin
        enc_word  = f_i;
        enc_legal = shift_op ? (i_imm[31:5] == 27'd0)
                             : imm_in_range(i_imm, IMM_I_MIN, IMM_I_MAX);
      end
      OP_JALR, OP_LOAD, OP_SYSTEM, OP_FENCE: begin
        enc_word  = f_i;
        enc_legal = imm_in_range(i_imm, IMM_I_MIN, IMM_I_MAX);
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // live keeps o_ready low during reset and raises it one edge after release.
  assign o_ready = live && (count != FULL_COUNT);
  assign o_valid = (count != '0);
  assign accept  = i_valid && o_ready;
  assign push    = accept && enc_legal;
  assign reject  = accept && !enc_legal;
  assign pop     = o_valid && i_ready;

  // Sticky is set alongside the pulse and again while the pulse is high,
  // so a clear coinciding with a live error never wins.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      live     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      live     <= 1'b1;
      err_q    <= reject;
      sticky_q <= reject || err_q || (sticky_q && !i_err_clr);
    end
  end

  assign o_err        = err_q;
  assign o_err_sticky = sticky_q;
  assign o_count      = count;

  hippo_encoder_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (enc_word),
    .i_pop   (pop),
    .o_data  (o_instr),
    .o_count (count)
  );

endmodule

// File: tb/tb_hippo_encoder.sv
// Bench for hippo_encoder: directed cases with literal words plus a
// randomized stream checked every cycle against a queue-based model and an
// independent bit-field decoder.
module tb_hippo_encoder;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_ALUI   = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_ALU    = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_BAD    = 7'h7F;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        sub;
    logic [31:0] imm;
  } req_t;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_valid;
  logic          o_ready;
  logic [6:0]    i_op;
  logic [4:0]    i_rd;
  logic [4:0]    i_rs1;
  logic [4:0]    i_rs2;
  logic [2:0]    i_funct3;
  logic          i_sub;
  logic [31:0]   i_imm;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_instr;
  logic          o_err;
  logic          o_err_sticky;
  logic          i_err_clr;
  logic [CW-1:0] o_count;

  always #5 i_clk = ~i_clk;

  hippo_encoder #(.DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op         (i_op),
    .i_rd         (i_rd),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_funct3     (i_funct3),
    .i_sub        (i_sub),
    .i_imm        (i_imm),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_instr      (o_instr),
    .o_err        (o_err),
    .o_err_sticky (o_err_sticky),
    .i_err_clr    (i_err_clr),
    .o_count      (o_count)
  );

  int   checks = 0;
  int   errors = 0;
  req_t q[$];
  req_t cur;
  bit   m_err, m_sticky, m_live;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_shift(input req_t r);
    return (r.op == OPC_ALUI) && ((r.f3 == 3'b001) || (r.f3 == 3'b101));
  endfunction

  function automatic bit is_legal(input req_t r);
    int v;
    v = r.imm;
    case (r.op)
      OPC_LUI, OPC_AUIPC: return r.imm[11:0] == 12'd0;
      OPC_JAL:    return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
      OPC_BRANCH: return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      OPC_ALU:    return 1'b1;
      OPC_ALUI:   return is_shift(r) ? (v >= 0 && v <= 31) : (v >= -2048 && v <= 2047);
      OPC_STORE, OPC_JALR, OPC_LOAD, OPC_SYSTEM, OPC_FENCE:
                  return (v >= -2048) && (v <= 2047);
      default:    return 1'b0;
    endcase
  endfunction

  // Full decode of a word; every format covers all 32 bits, so matching
  // every decoded field also proves the unused request fields were ignored.
  function automatic bit dec_ok(input logic [31:0] w, input req_t r);
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  f7_exp;
    bit ok;
    imm_i  = {{20{w[31]}}, w[31:20]};
    imm_s  = {{20{w[31]}}, w[31:25], w[11:7]};
    imm_b  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    imm_u  = {w[31:12], 12'b0};
    imm_j  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    f7_exp = {1'b0, r.sub, 5'b0};
    ok = (w[6:0] == r.op);
    case (r.op)
      OPC_LUI, OPC_AUIPC: ok = ok && (w[11:7] == r.rd) && (imm_u == r.imm);
      OPC_JAL:    ok = ok && (w[11:7] == r.rd) && (imm_j == r.imm);
      OPC_BRANCH: ok = ok && (w[19:15] == r.rs1) && (w[24:20] == r.rs2) &&
                       (w[14:12] == r.f3) && (imm_b == r.imm);
      OPC_STORE:  ok = ok && (w[19:15] == r.rs1) && (w[24:20] == r.rs2) &&
                       (w[14:12] == r.f3) && (imm_s == r.imm);
      OPC_ALU:    ok = ok && (w[11:7] == r.rd) && (w[19:15] == r.rs1) &&
                       (w[24:20] == r.rs2) && (w[14:12] == r.f3) && (w[31:25] == f7_exp);
      default: begin
        ok = ok && (w[11:7] == r.rd) && (w[19:15] == r.rs1) && (w[14:12] == r.f3);
        if (is_shift(r)) ok = ok && (w[24:20] == r.imm[4:0]) && (w[31:25] == f7_exp);
        else             ok = ok && (imm_i == r.imm);
      end
    endcase
    return ok;
  endfunction

  function automatic bit m_ready();
    return m_live && (q.size() != DEPTH);
  endfunction

  task automatic drive(input req_t r, input bit v);
    cur      = r;
    i_valid  = v;
    i_op     = r.op;
    i_rd     = r.rd;
    i_rs1    = r.rs1;
    i_rs2    = r.rs2;
    i_funct3 = r.f3;
    i_sub    = r.sub;
    i_imm    = r.imm;
  endtask

  task automatic compare_all();
    chk("ready", {31'b0, o_ready}, {31'b0, m_ready()});
    chk("valid", {31'b0, o_valid}, {31'b0, q.size() != 0});
    chk("count", 32'(o_count), 32'(q.size()));
    chk("err", {31'b0, o_err}, {31'b0, m_err});
    chk("sticky", {31'b0, o_err_sticky}, {31'b0, m_sticky});
    if (q.size() == 0) begin
      chk("instr_empty", o_instr, 32'h0);
    end else begin
      checks++;
      if (!dec_ok(o_instr, q[0])) begin
        errors++;
        $display("FAIL instr_roundtrip: got %h expected op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d sub=%0d imm=%h",
                 o_instr, q[0].op, q[0].rd, q[0].rs1, q[0].rs2, q[0].f3, q[0].sub, q[0].imm);
      end
    end
  endtask

  // One clock: predict the edge from the driven inputs, then check.
  task automatic step();
    bit   acc, leg, pop, clr, n_err;
    req_t r;
    r   = cur;
    clr = i_err_clr;
    acc = i_valid && m_ready();
    leg = is_legal(r);
    pop = (q.size() != 0) && i_ready;
    @(posedge i_clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc && leg) q.push_back(r);
    n_err    = acc && !leg;
    m_sticky = n_err || m_err || (m_sticky && !clr);
    m_err    = n_err;
    m_live   = 1'b1;
    compare_all();
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    #2;
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_ready", {31'b0, o_ready}, 32'h0);
    chk("rst_err", {31'b0, o_err}, 32'h0);
    chk("rst_sticky", {31'b0, o_err_sticky}, 32'h0);
    q.delete();
    m_err = 0; m_sticky = 0; m_live = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    chk("rst_ready_release", {31'b0, o_ready}, 32'h0);
  endtask

  function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic sub,
                              input logic [31:0] imm);
    req_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.sub = sub; r.imm = imm;
    return r;
  endfunction

  function automatic req_t gen_any();
    req_t r;
    logic [31:0] rnd;
    int lim, v;
    rnd = $urandom;
    case ($urandom_range(0, 11))
      0: r.op = OPC_LUI;    1: r.op = OPC_AUIPC;  2: r.op = OPC_JAL;
      3: r.op = OPC_JALR;   4: r.op = OPC_BRANCH; 5: r.op = OPC_LOAD;
      6: r.op = OPC_STORE;  7: r.op = OPC_ALUI;   8: r.op = OPC_ALU;
      9: r.op = OPC_FENCE;  10: r.op = OPC_SYSTEM;
      default: r.op = OPC_BAD;
    endcase
    r.rd = rnd[4:0]; r.rs1 = rnd[9:5]; r.rs2 = rnd[14:10]; r.f3 = rnd[17:15];
    r.sub = (r.op == OPC_ALU || is_shift(r)) ? rnd[18] : 1'b0;
    case (r.op)
      OPC_LUI, OPC_AUIPC: begin
        r.imm = $urandom & 32'hFFFFF000;
        if ($urandom_range(0, 7) == 0) r.imm[$urandom_range(0, 11)] = 1'b1;
      end
      OPC_ALU: r.imm = $urandom;
      default: begin
        if (is_shift(r)) begin
          v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(32, 40)) : int'($urandom_range(0, 31));
        end else begin
          lim = (r.op == OPC_JAL) ? (1 << 20) : (r.op == OPC_BRANCH) ? 4096 : 2048;
          v = int'($urandom_range(0, 2 * lim + 7)) - lim - 4;
          if ((r.op == OPC_JAL || r.op == OPC_BRANCH) && $urandom_range(0, 7) != 0) v = v & ~1;
        end
        r.imm = v;
      end
    endcase
    return r;
  endfunction

  function automatic req_t gen_legal();
    req_t r;
    for (int k = 0; k < 50; k++) begin
      r = gen_any();
      if (is_legal(r)) return r;
    end
    return mk(OPC_ALU, 5'd1, 5'd2, 5'd3, 3'd4, 1'b0, 32'h0);
  endfunction

  initial begin
    i_reset = 1'b0; i_ready = 1'b0; i_err_clr = 1'b0;
    drive(mk(OPC_ALU, 0, 0, 0, 0, 0, 0), 1'b0);
    do_reset();
    step();

    // Directed words, unused fields deliberately nonzero
    drive(mk(OPC_LUI, 5'd5, 5'd7, 5'd9, 3'd3, 1'b1, 32'h12345000), 1'b1);
    step();
    chk("lui_word", o_instr, 32'h123452B7);
    drive(mk(OPC_ALU, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'hDEAD), 1'b0);
    i_ready = 1'b1; step(); i_ready = 1'b0;

    drive(mk(OPC_ALU, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'hDEAD), 1'b1);
    step();
    chk("alu_word", o_instr, 32'h402081B3);
    i_valid = 1'b0; i_ready = 1'b1; step(); i_ready = 1'b0;

    drive(mk(OPC_BRANCH, 5'd31, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC), 1'b1);
    step();
    chk("branch_word", o_instr, 32'hFE208EE3);
    i_valid = 1'b0; i_ready = 1'b1; step(); i_ready = 1'b0;

    // Odd JAL offset is rejected
    drive(mk(OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3), 1'b1);
    step();
    chk("jal_err", {31'b0, o_err}, 32'h1);
    chk("jal_sticky", {31'b0, o_err_sticky}, 32'h1);
    chk("jal_count", 32'(o_count), 32'h0);
    i_valid = 1'b0; step();
    chk("jal_err_gone", {31'b0, o_err}, 32'h0);
    i_err_clr = 1'b1; step(); i_err_clr = 1'b0;
    chk("clr_sticky", {31'b0, o_err_sticky}, 32'h0);

    // Clear during a live error pulse: set wins
    i_valid = 1'b1; step();
    i_valid = 1'b0; i_err_clr = 1'b1; step();
    chk("set_wins", {31'b0, o_err_sticky}, 32'h1);
    step(); i_err_clr = 1'b0;
    chk("clr_after", {31'b0, o_err_sticky}, 32'h0);

    // Fill, then pop at full, then simultaneous push and pop
    for (int k = 0; k < DEPTH; k++) begin
      drive(gen_legal(), 1'b1);
      step();
    end
    chk("full_ready", {31'b0, o_ready}, 32'h0);
    chk("full_count", 32'(o_count), 32'(DEPTH));
    drive(gen_legal(), 1'b1); i_ready = 1'b1;
    step();
    chk("pop_at_full", 32'(o_count), 32'(DEPTH - 1));
    drive(gen_legal(), 1'b1);
    step();
    chk("push_pop_count", 32'(o_count), 32'(DEPTH - 1));
    i_valid = 1'b0;
    repeat (DEPTH + 1) step();

    // Random stream with a reset in the middle
    for (int n = 0; n < 800; n++) begin
      drive(gen_any(), $urandom_range(0, 3) != 0);
      i_ready   = ($urandom_range(0, 2) != 0);
      i_err_clr = ($urandom_range(0, 5) == 0);
      if (n == 400) begin
        do_reset();
        chk("mid_rst_count", 32'(o_count), 32'h0);
        chk("mid_rst_valid", {31'b0, o_valid}, 32'h0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
